// File: rtl/conv_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module  : conv_frame_encoder
// Purpose : Streaming frame encoder. Appends CRC-16 (when CONV_FRAME_CRC_EN is
//           defined) and applies rate-1/2 convolutional coding with zero tail.
// Rev     : 1.0
// ============================================================================
module conv_frame_encoder #(
    parameter int            FRAME_BITS = 32,
    parameter int            K          = 3,
    parameter logic [K-1:0]  G0         = 3'b111,
    parameter logic [K-1:0]  G1         = 3'b101,
    parameter logic [15:0]   CRC_POLY   = 16'h8005,
    parameter logic [15:0]   CRC_INIT   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_bit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_sym,
    output logic        out_last,
    output logic        frame_done,
    output logic [15:0] crc_value,
    output logic        busy
);

    localparam int CW = 12;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_CRC  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

`ifdef CONV_FRAME_CRC_EN
    localparam state_t ST_AFTER_DATA = ST_CRC;
    logic [15:0] r_crc;
    logic [15:0] w_crc_base;
    logic        w_crc_fb;
`else
    localparam state_t ST_AFTER_DATA = ST_TAIL;
`endif

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [K-2:0]    r_s;
    logic            r_out_valid;
    logic            r_out_last;
    logic [1:0]      r_out_sym;
    logic            w_out_free;
    logic            w_fed;
    logic            w_u;
    logic            w_adv;
    logic            w_tail_end;
    logic [K-1:0]    w_win;

    always_comb begin
        w_out_free    = !r_out_valid || out_ready;
        w_fed         = 1'b1;
        w_u           = 1'b0;
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + CW'(1);
        w_tail_end    = 1'b0;
        case (r_state)
            ST_DATA: begin
                w_fed = in_valid;
                w_u   = in_bit;
                if (r_bit_cnt == CW'(FRAME_BITS - 1)) begin
                    w_state_nxt   = ST_AFTER_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
`ifdef CONV_FRAME_CRC_EN
            ST_CRC: begin
                w_u = r_crc[15];
                if (r_bit_cnt == CW'(15)) begin
                    w_state_nxt   = ST_TAIL;
                    w_bit_cnt_nxt = '0;
                end
            end
`endif
            ST_TAIL: begin
                if (r_bit_cnt == CW'(K - 2)) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = '0;
                    w_tail_end    = 1'b1;
                end
            end
            default: begin
                w_fed         = 1'b0;
                w_state_nxt   = ST_DATA;
                w_bit_cnt_nxt = '0;
            end
        endcase
        w_adv = w_fed && w_out_free;
        w_win = {w_u, r_s};
    end

    // A beat only moves when the output register can take the new symbol.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_DATA;
            r_bit_cnt   <= '0;
            r_s         <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= 2'b00;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_s         <= w_tail_end ? '0 : w_win[K-1:1];
            r_out_valid <= 1'b1;
            r_out_sym   <= {^(w_win & G1), ^(w_win & G0)};
            r_out_last  <= w_tail_end;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

`ifdef CONV_FRAME_CRC_EN
    always_comb begin
        w_crc_base = (r_bit_cnt == '0) ? CRC_INIT : r_crc;
        w_crc_fb   = in_bit ^ w_crc_base[15];
    end

    // In the CRC state the register doubles as the shift-out source.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= CRC_INIT;
        end else if (w_adv) begin
            if (r_state == ST_DATA) begin
                r_crc <= {w_crc_base[14:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : 16'h0000);
            end else if (r_state == ST_CRC) begin
                r_crc <= {r_crc[14:0], 1'b0};
            end
        end
    end

    assign crc_value = r_crc;
`else
    logic w_unused_crc_cfg;
    assign w_unused_crc_cfg = ^{CRC_POLY, CRC_INIT};
    assign crc_value        = 16'h0000;
`endif

    assign in_ready   = (r_state == ST_DATA) && w_out_free;
    assign out_valid  = r_out_valid;
    assign out_sym    = r_out_sym;
    assign out_last   = r_out_last;
    assign frame_done = r_out_valid && out_ready && r_out_last;
    assign busy       = (r_state != ST_DATA) || (r_bit_cnt != '0) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_frame_encoder
// Purpose : Randomized self-checking bench with a queue-based frame model.
// Rev     : 1.0
// ============================================================================
module tb_conv_frame_encoder;

`ifdef CONV_FRAME_CRC_EN
    localparam int FB    = 72;
    localparam int NCRC  = 16;
`else
    localparam int FB    = 4;
    localparam int NCRC  = 0;
`endif
    localparam int           K        = 3;
    localparam logic [K-1:0] G0       = 3'b111;
    localparam logic [K-1:0] G1       = 3'b101;
    localparam logic [15:0]  CRC_POLY = 16'h8005;
    localparam logic [15:0]  CRC_INIT = 16'hFFFF;
    localparam int           SYMS     = FB + NCRC + K - 1;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_bit, out_ready;
    logic        in_ready, out_valid, out_last, frame_done, busy;
    logic [1:0]  out_sym;
    logic [15:0] crc_value;

    conv_frame_encoder #(
        .FRAME_BITS (FB),
        .K          (K),
        .G0         (G0),
        .G1         (G1),
        .CRC_POLY   (CRC_POLY),
        .CRC_INIT   (CRC_INIT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sym    (out_sym),
        .out_last   (out_last),
        .frame_done (frame_done),
        .crc_value  (crc_value),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          hist[$];
    bit          cur_frame[$];
    logic [1:0]  exp_sym[$];
    bit          exp_last[$];
    logic [1:0]  got_sym[$];
    bit          got_last[$];
    int          got_cyc[$];
    int          fd_cnt = 0;
    int          cyc_no = 0;
    logic [15:0] crc_run = CRC_INIT;
    logic [15:0] crc_exp = CRC_INIT;
    logic [15:0] crc_at_entry = 16'h0;
    bit          crc_chk = 0, crc_end = 0;
    bit          prev_rst = 0, prev_stall = 0, prev_last = 0;
    logic [1:0]  prev_sym = 2'b00;

    // Window bit i holds the feed bit from K-1-i beats ago; missing history is 0.
    function automatic logic [1:0] conv_sym(input bit h[$], input bit u);
        bit p0 = 0, p1 = 0, b;
        for (int i = 0; i < K; i++) begin
            if (i == K - 1)                  b = u;
            else if (h.size() >= K - 1 - i)  b = h[h.size() - (K - 1 - i)];
            else                             b = 0;
            p0 ^= G0[i] & b;
            p1 ^= G1[i] & b;
        end
        return {p1, p0};
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
        bit fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    function automatic logic [15:0] crc16(input bit bits[$]);
        logic [15:0] c = CRC_INIT;
        foreach (bits[i]) c = crc_step(c, bits[i]);
        return c;
    endfunction

    task automatic feed(input bit u, input bit last);
        exp_sym.push_back(conv_sym(hist, u));
        exp_last.push_back(last);
        hist.push_back(u);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        cyc_no++;
        if (prev_rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sym", out_sym, 0);
            check("rst_out_last", out_last, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 1);
`ifdef CONV_FRAME_CRC_EN
            check("rst_crc", crc_value, CRC_INIT);
`endif
        end
`ifdef CONV_FRAME_CRC_EN
        if (crc_chk) check("crc_value", crc_value, crc_exp);
        if (crc_end) begin
            crc_at_entry = crc_value;
            crc_chk = 0;
            crc_end = 0;
        end
`else
        check("crc_tied", crc_value, 16'h0000);
`endif
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_sym", out_sym, prev_sym);
            check("stall_last", out_last, prev_last);
        end
        if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
        check("busy", busy, (cur_frame.size() != 0 || exp_sym.size() != 0));
        if (out_valid && out_ready) begin
            if (exp_sym.size() == 0) begin
                check("extra_sym", 1, 0);
            end else begin
                check("out_sym", out_sym, exp_sym[0]);
                check("out_last", out_last, exp_last[0]);
                check("frame_done", frame_done, exp_last[0]);
                void'(exp_sym.pop_front());
                void'(exp_last.pop_front());
            end
            got_sym.push_back(out_sym);
            got_last.push_back(out_last);
            got_cyc.push_back(cyc_no);
            if (frame_done) fd_cnt++;
        end else begin
            check("frame_done_idle", frame_done, 0);
        end
        prev_stall = out_valid && !out_ready && !reset;
        prev_sym   = out_sym;
        prev_last  = out_last;
        if (reset) begin
            hist.delete();
            cur_frame.delete();
            exp_sym.delete();
            exp_last.delete();
            crc_chk = 0;
            crc_end = 0;
        end else if (in_valid && in_ready) begin
            if (cur_frame.size() == 0) crc_run = CRC_INIT;
            crc_run = crc_step(crc_run, in_bit);
            crc_exp = crc_run;
            crc_chk = 1;
            feed(in_bit, 0);
            cur_frame.push_back(in_bit);
            if (cur_frame.size() == FB) begin
`ifdef CONV_FRAME_CRC_EN
                for (int i = 15; i >= 0; i--) feed(crc_run[i], 0);
                crc_end = 1;
`else
                crc_chk = 0;
`endif
                for (int i = 0; i < K - 1; i++) feed(0, i == K - 2);
                hist.delete();
                cur_frame.delete();
            end
        end
        prev_rst = reset;
    end

    // ---------------- stimulus ----------------
    int ph = 0;

    function automatic logic rdy(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return (ph % 4 == 0) || (ph % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit bits[$], input int gap_pct, input int mode,
                             input int rst_at, input int gap_at);
        int  idx = 0, cyc = 0, gap_left = 3;
        bit  acc;
        while (idx < bits.size() && cyc < 5000) begin
            in_valid = 1'b1;
            if (idx == gap_at && gap_left > 0) begin
                in_valid = 1'b0;
                gap_left--;
            end else if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
            end
            in_bit    = in_valid ? bits[idx] : 1'($urandom_range(0, 1));
            out_ready = rdy(mode);
            ph++;
            reset = (idx == rst_at);
            @(negedge clk);
            acc = in_valid && in_ready && !reset;
            step();
            if (reset) begin
                reset    = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 5000) check("input_timeout", 1, 0);
    endtask

    task automatic drain(input int mode);
        int c = 0;
        while (exp_sym.size() != 0 && c < 5000) begin
            out_ready = rdy(mode);
            ph++;
            step();
            c++;
        end
        out_ready = 1'b1;
        step();
        if (c >= 5000) check("drain_timeout", 1, 0);
    endtask

    function automatic void rand_bits(output bit q[$]);
        q.delete();
        for (int i = 0; i < FB; i++) q.push_back(1'($urandom_range(0, 1)));
    endfunction

    task automatic clear_log();
        got_sym.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    initial begin
        bit          fr[$], fr2[$];
        logic [1:0]  ref_sym[$];
        int          fd0;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

`ifdef CONV_FRAME_CRC_EN
        begin
            string s = "123456789";
            byte   ch;
            fr.delete();
            for (int i = 0; i < s.len(); i++) begin
                ch = s[i];
                for (int j = 7; j >= 0; j--) fr.push_back(ch[j]);
            end
            check("model_crc_pin", crc16(fr), 16'hAEE7);
            clear_log();
            run_frame(fr, 0, 0, -1, -1);
            drain(0);
            check("crc_check_entry", crc_at_entry, 16'hAEE7);
            check("crc_frame_len", got_sym.size(), SYMS);
        end
`else
        begin
            logic [1:0] imp [6];
            imp = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
            fr = '{1, 0, 0, 0};
            check("model_conv_pin", conv_sym(hist, 1'b1), 2'b11);
            clear_log();
            fd0 = fd_cnt;
            run_frame(fr, 0, 1, -1, -1);
            drain(1);
            check("imp_len", got_sym.size(), 6);
            for (int i = 0; i < 6 && i < got_sym.size(); i++) begin
                check($sformatf("imp_sym%0d", i), got_sym[i], imp[i]);
                check($sformatf("imp_last%0d", i), got_last[i], (i == 5));
            end
            check("imp_frame_done_cnt", fd_cnt - fd0, 1);
        end
`endif

        // Back-to-back frames with no bubbles.
        rand_bits(fr);
        rand_bits(fr2);
        clear_log();
        run_frame(fr, 0, 0, -1, -1);
        run_frame(fr2, 0, 0, -1, -1);
        drain(0);
        check("b2b_len", got_sym.size(), 2 * SYMS);
        if (got_sym.size() == 2 * SYMS) begin
            check("b2b_contig", got_cyc[2*SYMS-1] - got_cyc[0], 2 * SYMS - 1);
            check("b2b_last1", got_last[SYMS-1], 1);
            check("b2b_last2", got_last[2*SYMS-1], 1);
            check("b2b_notlast", got_last[SYMS-2], 0);
        end

        // Reset mid-frame, then a full frame.
        rand_bits(fr);
        run_frame(fr, 0, 2, (FB > 10) ? 10 : FB / 2, -1);
        step();
        run_frame(fr, 20, 2, -1, -1);
        drain(2);

        // Input gap yields the same symbols as a gap-free run.
        rand_bits(fr);
        clear_log();
        run_frame(fr, 0, 0, -1, -1);
        drain(0);
        ref_sym = got_sym;
        clear_log();
        run_frame(fr, 0, 0, -1, (FB > 5) ? 5 : 1);
        drain(0);
        check("gap_len", got_sym.size(), ref_sym.size());
        for (int i = 0; i < got_sym.size() && i < ref_sym.size(); i++)
            check($sformatf("gap_sym%0d", i), got_sym[i], ref_sym[i]);

        // Random frames, random gaps and back-pressure.
        for (int f = 0; f < 8; f++) begin
            rand_bits(fr);
            run_frame(fr, 30, 2, -1, -1);
        end
        drain(2);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
